// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory-subsystem FSM states, fault causes, and CPU opcode encodings.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DONE,
    ST_FAULT
  } mem_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_DATA_RW_BOTH,
    CAUSE_DATA_MISALIGN,
    CAUSE_DATA_RANGE,
    CAUSE_INSTR
  } fault_cause_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21
  } funct_e;

  // True when the word index of a byte address falls inside a memory of 'depth' words.
  function automatic logic word_in_range(input logic [31:0] addr, input int unsigned depth);
    return {2'b00, addr[31:2]} < depth;
  endfunction

endpackage

// File: rtl/mips_harvard_mem_if.sv
// Preload, instruction-fetch and data-access signals between the CPU side and the memory subsystem.
interface mips_harvard_mem_if;
  logic        load_valid;
  logic        load_ready;
  logic        load_target;
  logic [31:0] load_data;
  logic        load_last;
  logic        cpu_active;
  logic        cpu_clk_enable;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        fault;
  logic [31:0] fault_addr;
  logic [15:0] write_count;

  modport master (
    output load_valid, load_target, load_data, load_last, cpu_active,
           instr_address, data_address, data_read, data_write, data_writedata,
    input  load_ready, cpu_clk_enable, instr_readdata, data_readdata,
           fault, fault_addr, write_count
  );

  modport slave (
    input  load_valid, load_target, load_data, load_last, cpu_active,
           instr_address, data_address, data_read, data_write, data_writedata,
    output load_ready, cpu_clk_enable, instr_readdata, data_readdata,
           fault, fault_addr, write_count
  );
endinterface

// File: rtl/mips_ram_1r1w.sv
// Word memory with one combinational read port and one synchronous write port.
module mips_ram_1r1w #(
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  // NOTE: the array has no reset; contents must survive reset and a reset port would block RAM inference.
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_harvard_mem.sv
// Harvard memory subsystem: preloads instruction ROM / data RAM, then serves a CPU until done or fault.
module mips_harvard_mem
  import mips_pkg::*;
#(
  parameter int unsigned INSTR_WORDS = 256,
  parameter int unsigned DATA_WORDS  = 256
) (
  input  logic         clk,
  input  logic         reset,
  mips_harvard_mem_if.slave bus
);

  localparam int unsigned IAW = $clog2(INSTR_WORDS);
  localparam int unsigned DAW = $clog2(DATA_WORDS);
  localparam int unsigned IPW = IAW + 1;  // pointers must be able to hold the depth itself
  localparam int unsigned DPW = DAW + 1;

  mem_state_e   state_q, state_d;
  logic [IPW-1:0] ip_q, ip_d;
  logic [DPW-1:0] dp_q, dp_d;
  logic [31:0]  fault_addr_q, fault_addr_d;
  logic [15:0]  write_count_q, write_count_d;
  logic         cpu_active_q, cpu_active_d;

  logic         rom_we, ram_we;
  logic [DAW-1:0] ram_waddr;
  logic [31:0]  ram_wdata, rom_rdata, ram_rdata;
  logic         load_sel_full, instr_in_range, data_in_range, data_fault;
  logic [31:0]  load_ptr_bytes;
  fault_cause_e run_cause;

  assign instr_in_range = word_in_range(bus.instr_address, INSTR_WORDS);
  assign data_in_range  = word_in_range(bus.data_address, DATA_WORDS);
  assign load_sel_full  = bus.load_target ? (dp_q == DPW'(DATA_WORDS)) : (ip_q == IPW'(INSTR_WORDS));
  assign load_ptr_bytes = bus.load_target ? (32'(dp_q) << 2) : (32'(ip_q) << 2);

  // Data-port causes outrank the instruction port so the data address is the one captured.
  always_comb begin
    run_cause = CAUSE_NONE;
    if (bus.data_read && bus.data_write)
      run_cause = CAUSE_DATA_RW_BOTH;
    else if ((bus.data_read || bus.data_write) && bus.data_address[1:0] != 2'b00)
      run_cause = CAUSE_DATA_MISALIGN;
    else if ((bus.data_read || bus.data_write) && !data_in_range)
      run_cause = CAUSE_DATA_RANGE;
    else if (bus.instr_address[1:0] != 2'b00 || !instr_in_range)
      run_cause = CAUSE_INSTR;
  end

  assign data_fault = (run_cause != CAUSE_NONE) && (run_cause != CAUSE_INSTR);

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ip_d          = ip_q;
    dp_d          = dp_q;
    fault_addr_d  = fault_addr_q;
    write_count_d = write_count_q;
    cpu_active_d  = 1'b0;
    rom_we        = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = bus.data_address[DAW+1:2];
    ram_wdata     = bus.data_writedata;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.load_valid) begin
          if (load_sel_full) begin
            state_d      = ST_FAULT;
            fault_addr_d = load_ptr_bytes;
          end else begin
            if (bus.load_target) begin
              ram_we    = 1'b1;
              ram_waddr = dp_q[DAW-1:0];
              ram_wdata = bus.load_data;
              dp_d      = dp_q + 1'b1;
            end else begin
              rom_we = 1'b1;
              ip_d   = ip_q + 1'b1;
            end
            if (bus.load_last) state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cpu_active_d = bus.cpu_active;
        if (run_cause != CAUSE_NONE) begin
          state_d      = ST_FAULT;
          fault_addr_d = (run_cause == CAUSE_INSTR) ? bus.instr_address : bus.data_address;
        end else if (cpu_active_q && !bus.cpu_active) begin
          state_d = ST_DONE;
        end
        if (bus.data_write && !data_fault) begin
          ram_we = 1'b1;
          if (write_count_q != 16'hFFFF) write_count_d = write_count_q + 16'd1;
        end
      end
      default: ;  // DONE and FAULT hold everything until reset
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      ip_q          <= '0;
      dp_q          <= '0;
      fault_addr_q  <= '0;
      write_count_q <= '0;
      cpu_active_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ip_q          <= ip_d;
      dp_q          <= dp_d;
      fault_addr_q  <= fault_addr_d;
      write_count_q <= write_count_d;
      cpu_active_q  <= cpu_active_d;
    end
  end

  mips_ram_1r1w #(.DEPTH(INSTR_WORDS)) u_rom (
    .clk     (clk),
    .we_i    (rom_we),
    .waddr_i (ip_q[IAW-1:0]),
    .wdata_i (bus.load_data),
    .raddr_i (bus.instr_address[IAW+1:2]),
    .rdata_o (rom_rdata)
  );

  mips_ram_1r1w #(.DEPTH(DATA_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (bus.data_address[DAW+1:2]),
    .rdata_o (ram_rdata)
  );

  assign bus.load_ready     = (state_q == ST_LOAD);
  assign bus.cpu_clk_enable = (state_q == ST_RUN);
  assign bus.fault          = (state_q == ST_FAULT);
  assign bus.fault_addr     = fault_addr_q;
  assign bus.write_count    = write_count_q;
  assign bus.instr_readdata = instr_in_range ? rom_rdata : 32'h0;
  assign bus.data_readdata  = (bus.data_read && data_in_range) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Scoreboard bench for mips_harvard_mem: directed scenarios plus randomized episodes against a
// behavioural model of the preload / run / done / fault rules.
module tb_mips_harvard_mem;

  localparam int unsigned IW = 16;
  localparam int unsigned DW = 4;
  localparam int M_LOAD = 0, M_RUN = 1, M_DONE = 2, M_FAULT = 3;

  typedef struct {
    bit        rst;
    bit        lv;
    bit        lt;
    bit [31:0] ld;
    bit        ll;
    bit        act;
    bit [31:0] ia;
    bit [31:0] da;
    bit        rd;
    bit        wr;
    bit [31:0] wd;
  } stim_t;

  typedef struct {
    bit        cen;
    bit        lrdy;
    bit        flt;
    bit [31:0] faddr;
    bit [15:0] wcnt;
    bit [31:0] ird;
    bit        ird_known;
    bit [31:0] drd;
    bit        drd_known;
  } exp_t;

  logic clk = 1'b1;
  logic reset;
  always #5 clk = ~clk;

  mips_harvard_mem_if bus ();

  mips_harvard_mem #(.INSTR_WORDS(IW), .DATA_WORDS(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  exp_t sb_q[$];

  // Reference model: memory images, fill pointers and the operating mode.
  bit [31:0] m_rom [IW];
  bit        m_rom_known [IW];
  bit [31:0] m_ram [DW];
  bit        m_ram_known [DW];
  int unsigned m_ip, m_dp;
  int        m_mode;
  bit [31:0] m_faddr;
  bit [15:0] m_wcnt;
  bit        m_act_prev;
  bit        m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t expect_now(stim_t s);
    exp_t e;
    e.cen       = (m_mode == M_RUN);
    e.lrdy      = (m_mode == M_LOAD);
    e.flt       = (m_mode == M_FAULT);
    e.faddr     = m_faddr;
    e.wcnt      = m_wcnt;
    e.ird       = 32'h0;
    e.ird_known = 1'b1;
    if (s.ia / 4 < IW) begin
      e.ird       = m_rom[s.ia / 4];
      e.ird_known = m_rom_known[s.ia / 4];
    end
    e.drd       = 32'h0;
    e.drd_known = 1'b1;
    if (s.rd && s.da / 4 < DW) begin
      e.drd       = m_ram[s.da / 4];
      e.drd_known = m_ram_known[s.da / 4];
    end
    return e;
  endfunction

  function automatic void model_edge(stim_t s);
    int unsigned ptr, depth;
    bit dbad, was_run;
    was_run = (m_mode == M_RUN);
    if (s.rst) begin
      m_mode = M_LOAD; m_ip = 0; m_dp = 0; m_faddr = 0; m_wcnt = 0;
      m_act_prev = 1'b0; m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    case (m_mode)
      M_LOAD: if (s.lv) begin
        ptr   = s.lt ? m_dp : m_ip;
        depth = s.lt ? DW : IW;
        if (ptr == depth) begin
          m_mode  = M_FAULT;
          m_faddr = ptr * 4;
        end else begin
          if (s.lt) begin m_ram[ptr] = s.ld; m_ram_known[ptr] = 1'b1; m_dp++; end
          else      begin m_rom[ptr] = s.ld; m_rom_known[ptr] = 1'b1; m_ip++; end
          if (s.ll) m_mode = M_RUN;
        end
      end
      M_RUN: begin
        dbad = (s.rd && s.wr) || ((s.rd || s.wr) && (s.da % 4 != 0 || s.da / 4 >= DW));
        if (dbad) begin
          m_mode = M_FAULT; m_faddr = s.da;
        end else if (s.ia % 4 != 0 || s.ia / 4 >= IW) begin
          m_mode = M_FAULT; m_faddr = s.ia;
        end else if (m_act_prev && !s.act) begin
          m_mode = M_DONE;
        end
        if (s.wr && !dbad) begin
          m_ram[s.da / 4] = s.wd;
          m_ram_known[s.da / 4] = 1'b1;
          if (m_wcnt != 16'hFFFF) m_wcnt++;
        end
      end
      default: ;
    endcase
    m_act_prev = was_run && s.act;
  endfunction

  task automatic apply(stim_t s);
    reset              = s.rst;
    bus.load_valid     = s.lv;
    bus.load_target    = s.lt;
    bus.load_data      = s.ld;
    bus.load_last      = s.ll;
    bus.cpu_active     = s.act;
    bus.instr_address  = s.ia;
    bus.data_address   = s.da;
    bus.data_read      = s.rd;
    bus.data_write     = s.wr;
    bus.data_writedata = s.wd;
  endtask

  // Drive one cycle's inputs, queue what the outputs must show before the edge, then advance.
  task automatic step(stim_t s);
    apply(s);
    if (m_known) sb_q.push_back(expect_now(s));
    model_edge(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.act = 1'b1;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s;
    s = idle(); s.rst = 1'b1;
    step(s);
  endtask

  task automatic load_word(bit tgt, bit [31:0] d, bit last);
    stim_t s;
    s = idle(); s.lv = 1'b1; s.lt = tgt; s.ld = d; s.ll = last;
    step(s);
  endtask

  task automatic data_op(bit [31:0] da, bit rd, bit wr, bit [31:0] wd, bit act);
    stim_t s;
    s = idle(); s.da = da; s.rd = rd; s.wr = wr; s.wd = wd; s.act = act;
    step(s);
  endtask

  function automatic stim_t rand_run();
    stim_t s;
    int unsigned r;
    s = idle();
    s.ia  = $urandom_range(0, IW - 1) * 4;
    if ($urandom_range(0, 49) == 0) s.ia = $urandom_range(0, 1) ? (s.ia | 32'h2) : IW * 4;
    s.act = ($urandom_range(0, 29) != 0);
    s.wd  = $urandom;
    r = $urandom_range(0, 99);
    if (r < 35)      begin s.rd = 1'b1; s.da = $urandom_range(0, DW - 1) * 4; end
    else if (r < 65) begin s.wr = 1'b1; s.da = $urandom_range(0, DW - 1) * 4; end
    else if (r < 69) begin s.rd = $urandom_range(0, 1); s.wr = !s.rd; s.da = $urandom_range(0, DW * 4 - 1) | 32'h1; end
    else if (r < 72) begin s.rd = $urandom_range(0, 1); s.wr = !s.rd; s.da = (DW + $urandom_range(0, 100)) * 4; end
    else if (r < 74) begin s.rd = 1'b1; s.wr = 1'b1; s.da = $urandom_range(0, DW - 1) * 4; end
    return s;
  endfunction

  // Monitor: pops one expectation per cycle and compares mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("cpu_clk_enable", 32'(bus.cpu_clk_enable), 32'(e.cen));
        check("load_ready", 32'(bus.load_ready), 32'(e.lrdy));
        check("fault", 32'(bus.fault), 32'(e.flt));
        check("fault_addr", bus.fault_addr, e.faddr);
        check("write_count", 32'(bus.write_count), 32'(e.wcnt));
        if (e.ird_known) check("instr_readdata", bus.instr_readdata, e.ird);
        if (e.drd_known) check("data_readdata", bus.data_readdata, e.drd);
      end
    end
  end

  initial begin
    stim_t s;
    int unsigned n;
    #1;
    do_reset();
    do_reset();
    step(idle());
    step(idle());

    // Program image and one data word, then reads in RUN.
    load_word(1'b0, 32'h24020005, 1'b0);
    load_word(1'b0, 32'h00000000, 1'b0);
    step(idle());
    load_word(1'b0, 32'h03E00008, 1'b0);
    load_word(1'b1, 32'hDEADBEEF, 1'b1);
    s = idle(); s.ia = 32'h4; step(s);
    s = idle(); s.ia = 32'h8; s.rd = 1'b1; step(s);

    // Write then read back; write counter advances.
    data_op(32'h8, 1'b0, 1'b1, 32'h12345678, 1'b1);
    data_op(32'h8, 1'b1, 1'b0, 32'h0, 1'b1);
    data_op(32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

    // cpu_active falls -> DONE; writes ignored, reads still live.
    data_op(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    data_op(32'h0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0);
    data_op(32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    data_op(32'h8, 1'b1, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of RUN.
    do_reset();
    load_word(1'b1, 32'h0000_00AA, 1'b1);
    data_op(32'h4, 1'b0, 1'b1, 32'h5555AAAA, 1'b1);
    data_op(32'hC, 1'b0, 1'b1, 32'h01020304, 1'b1);
    do_reset();
    step(idle());
    data_op(32'h4, 1'b1, 1'b0, 32'h0, 1'b1);

    // Misaligned data read faults; fault is sticky and blocks writes.
    do_reset();
    load_word(1'b1, 32'h0BADF00D, 1'b1);
    data_op(32'h6, 1'b1, 1'b0, 32'h0, 1'b1);
    data_op(32'h0, 1'b0, 1'b1, 32'hFFFF0000, 1'b1);
    data_op(32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    load_word(1'b1, 32'h1, 1'b1);

    // Five data words into a four-word RAM.
    do_reset();
    for (int k = 0; k < 5; k++) load_word(1'b1, 32'hA000_0000 + k, (k == 4));
    step(idle());
    step(idle());

    // Both ports fault together: data address wins. Then instruction-only and read+write faults.
    do_reset();
    load_word(1'b1, 32'h77, 1'b1);
    s = idle(); s.ia = 32'h2; s.da = 32'h5; s.rd = 1'b1; step(s);
    step(idle());
    do_reset();
    load_word(1'b0, 32'h11, 1'b1);
    s = idle(); s.ia = IW * 4; step(s);
    step(idle());
    do_reset();
    load_word(1'b1, 32'h22, 1'b1);
    data_op(32'h0, 1'b1, 1'b1, 32'h33, 1'b1);
    data_op(32'h0, 1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      n = $urandom_range(1, 7);
      for (int k = 0; k < int'(n); k++) begin
        while ($urandom_range(0, 3) == 0) step(idle());
        load_word($urandom_range(0, 1), $urandom, (k == int'(n) - 1));
      end
      for (int c = 0; c < 40; c++) step(rand_run());
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_harvard_mem.md
MIPS_HARVARD_MEM -- requirements
Module: mips_harvard_mem

Interface
REQ-001 Parameter INSTR_WORDS, default 256: instruction ROM depth in 32-bit words; power of two.
REQ-002 Parameter DATA_WORDS, default 256: data RAM depth in 32-bit words; power of two.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 load_valid / load_ready  input / output  1 / 1  preload word handshake.
REQ-006 load_target  input  1  destination of the preload word: 0 = instruction ROM, 1 = data RAM.
REQ-007 load_data  input  32  preload word.
REQ-008 load_last  input  1  marks the final preload word.
REQ-009 cpu_active  input  1  CPU active flag.
REQ-010 cpu_clk_enable  output  1  clock enable to the CPU.
REQ-011 instr_address / instr_readdata  input / output  32 / 32  combinational instruction read.
REQ-012 data_address, data_read, data_write, data_writedata  input  32, 1, 1, 32  data access request.
REQ-013 data_readdata  output  32  combinational data read result.
REQ-014 fault  output  1  sticky access fault.
REQ-015 fault_addr  output  32  address that caused the first fault.
REQ-016 write_count  output  16  count of accepted CPU data writes.

Function
REQ-017 FSM states: LOAD, RUN, DONE, FAULT; reset enters LOAD.
REQ-018 LOAD: load_ready=1, cpu_clk_enable=0; a word transfers when load_valid && load_ready.
REQ-019 A transferred word writes at ip (load_target=0) or dp (load_target=1), then that pointer increments by 1.
REQ-020 A transfer while the selected pointer already equals its depth writes nothing and enters FAULT with fault_addr = pointer*4.
REQ-021 A transfer with load_last=1 enters RUN on the next cycle; no transfer holds LOAD indefinitely.
REQ-022 RUN: cpu_clk_enable=1, load_ready=0.
REQ-023 instr_readdata = ROM[instr_address>>2] in the same cycle when in range; 32'h0 otherwise.
REQ-024 data_readdata = RAM[data_address>>2] combinationally when data_read and in range; 32'h0 otherwise.
REQ-025 data_write in RUN writes data_writedata to RAM at the rising edge; write visible to reads next cycle.
REQ-026 write_count increments on each accepted write; saturates at 16'hFFFF.
REQ-027 In RUN, these enter FAULT and capture fault_addr=data_address: data_address[1:0]!=0 with data_read or data_write; out-of-range data address; data_read && data_write together.
REQ-028 A faulting write does not modify RAM.
REQ-029 instr_address misaligned or out of range in RUN enters FAULT with fault_addr=instr_address.
REQ-030 If both ports fault in the same cycle, the data address is captured.
REQ-031 cpu_active falling (1 to 0 across consecutive RUN cycles) enters DONE; cpu_clk_enable=0, reads stay live.
REQ-032 FAULT: cpu_clk_enable=0, load_ready=0, fault=1; exit only by reset.
REQ-033 DONE and FAULT ignore data_write.

Reset
REQ-034 Reset sets state=LOAD, ip=dp=0, fault=0, fault_addr=0, write_count=0, cpu_clk_enable=0, load_ready=1 on the cycle after reset.
REQ-035 ROM/RAM contents are not cleared by reset.
REQ-036 Reset mid-load or mid-run restarts preload at word 0; partially loaded words remain until overwritten.

Structure
REQ-037 State enum and the fault-cause constants go in shared package mips_pkg, alongside the CPU opcode enums.
REQ-038 One sub-module, mips_ram_1r1w (one combinational read port, one synchronous write port), is instantiated twice: ROM and RAM.
REQ-039 The FSM, pointers, fault capture and counter live in mips_harvard_mem itself.

Verification
REQ-040 Load ROM 3 words {0x24020005, 0x00000000, 0x03E00008} and last data word 0xDEADBEEF -> RUN; instr_address=4 reads 0; data_address=0 with data_read reads 0xDEADBEEF.
REQ-041 RUN, data_write at 0x8 with value 0x12345678, then data_read at 0x8 -> 0x12345678 next cycle; write_count=1.
REQ-042 RUN, data_read at 0x6 -> fault=1, fault_addr=0x6, cpu_clk_enable=0 the next cycle.
REQ-043 DATA_WORDS=4, send 5 data words -> the fifth sets fault, fault_addr=0x10.
REQ-044 RUN, cpu_active 1 then 0 -> DONE, cpu_clk_enable=0; a data_write at 0x0 is ignored.
REQ-045 Reset asserted mid-RUN -> LOAD next cycle, write_count=0, fault=0, load_ready=1.
